// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-domain pointer, Gray publish and full/level flags for the async FIFO
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic                  ovf_clr,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int A     = ADDR_WIDTH;
  localparam int DEPTH = 1 << A;
  localparam logic [A:0] AFULL_LVL = (A+1)'(DEPTH - AFULL_THRESH);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [A:0] bin2gray(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [A:0]   wbin_q, wbin_d;
  logic [A-1:0] wr_addr_q, wr_addr_d;
  logic [A:0]   wptr_gray_q, wptr_gray_d;
  logic         full_q, full_d;
  logic         almost_full_q, almost_full_d;
  logic [A:0]   wr_level_q, wr_level_d;
  logic         overflow_q, overflow_d;
  logic [A:0]   rbin;
  logic [A:0]   full_pattern;

  // Full is registered, so a write landing while full is simply refused.
  assign wr_accept = wr_en & ~full_q;

  // Next-state for pointer, Gray publish, flags and the sticky overflow.
  always_comb begin
    rbin          = gray2bin(rptr_gray_sync);
    wbin_d        = wbin_q + {{A{1'b0}}, wr_accept};
    wr_addr_d     = wbin_d[A-1:0];
    wptr_gray_d   = bin2gray(wbin_d);
    // Writer is a full lap ahead: top two Gray bits inverted, the rest equal.
    full_pattern  = {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]};
    full_d        = (wptr_gray_d == full_pattern);
    wr_level_d    = wbin_d - rbin;
    almost_full_d = (wr_level_d >= AFULL_LVL);
    // A new overflow event outranks a simultaneous clear.
    overflow_d    = (wr_en & full_q) | (overflow_q & ~ovf_clr);
  end

  // All state clears asynchronously so the pointer restarts together with the read side.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wbin_q        <= '0;
      wr_addr_q     <= '0;
      wptr_gray_q   <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_level_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wr_addr_q     <= wr_addr_d;
      wptr_gray_q   <= wptr_gray_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wr_level_q    <= wr_level_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wptr_gray   = wptr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_level    = wr_level_q;
  assign overflow    = overflow_q;

endmodule
